pwm_fade_sequencer: RTL and testbench

//  Duty-cycle controller between the SPI register bank and pwm_peripheral. Drives
//  pwm_duty_cycle, which is either written directly over SPI or ramped toward a

---
 rtl/pwm_fade_sequencer_pkg.sv | 19 +
 rtl/pwm_fade_sequencer_if.sv | 32 +++
 rtl/pwm_fade_sequencer_tick_timer.sv | 28 ++
 rtl/pwm_fade_sequencer.sv | 128 ++++++++++++
 tb/tb_pwm_fade_sequencer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_fade_sequencer_pkg.sv
// Shared definitions for the PWM fade sequencer: default widths, the FSM
// state type and a helper that maps a zero step or interval to one.
package pwm_fade_sequencer_pkg;

  localparam int DUTY_W = 8;
  localparam int STEP_W = 4;
  localparam int IVL_W  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } fade_state_e;

  // A zero step or zero interval would stall a fade, so both read as one.
  function automatic int unsigned clampToOne(input int unsigned value);
    return (value == 0) ? 1 : value;
  endfunction

endpackage

// File: rtl/pwm_fade_sequencer_if.sv
// Bundle between the SPI register bank (master) and the fade sequencer
// (slave): duty/fade configuration in, registered duty and status out.
interface pwm_fade_sequencer_if #(
  parameter int DUTY_W = pwm_fade_sequencer_pkg::DUTY_W,
  parameter int STEP_W = pwm_fade_sequencer_pkg::STEP_W,
  parameter int IVL_W  = pwm_fade_sequencer_pkg::IVL_W
) ();

  logic [DUTY_W-1:0] cfg_duty;
  logic              cfg_duty_wr;
  logic              fade_start;
  logic              fade_abort;
  logic [DUTY_W-1:0] fade_target;
  logic [STEP_W-1:0] fade_step;
  logic [IVL_W-1:0]  fade_interval;
  logic [DUTY_W-1:0] pwm_duty_cycle;
  logic              busy;
  logic              done;

  modport master (
    output cfg_duty, cfg_duty_wr, fade_start, fade_abort,
           fade_target, fade_step, fade_interval,
    input  pwm_duty_cycle, busy, done
  );

  modport slave (
    input  cfg_duty, cfg_duty_wr, fade_start, fade_abort,
           fade_target, fade_step, fade_interval,
    output pwm_duty_cycle, busy, done
  );

endinterface

// File: rtl/pwm_fade_sequencer_tick_timer.sv
// Step-interval down-counter for the fade sequencer. A load sets the count;
// otherwise it counts down and rests at zero, where tick_o is asserted.
module fade_tick_timer #(
  parameter int IVL_W = pwm_fade_sequencer_pkg::IVL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [IVL_W-1:0] load_val_i,
  output logic             tick_o
);

  logic [IVL_W-1:0] count_q;

  // Load takes precedence over counting; the counter never wraps below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign tick_o = (count_q == '0);

endmodule

// File: rtl/pwm_fade_sequencer.sv
// Duty-cycle controller feeding pwm_peripheral. The duty is either written
// directly or ramped toward a target in fixed steps, one step per interval.
module pwm_fade_sequencer #(
  parameter int DUTY_W = pwm_fade_sequencer_pkg::DUTY_W,
  parameter int STEP_W = pwm_fade_sequencer_pkg::STEP_W,
  parameter int IVL_W  = pwm_fade_sequencer_pkg::IVL_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pwm_fade_sequencer_if.slave  bus
);

  import pwm_fade_sequencer_pkg::*;

  localparam int GAP_W = DUTY_W + 1;

  fade_state_e       state_q;
  logic [DUTY_W-1:0] duty_q;
  logic [DUTY_W-1:0] target_q;
  logic [STEP_W-1:0] step_q;
  logic [IVL_W-1:0]  ivlm1_q;
  logic              dir_up_q;
  logic              busy_q;
  logic              done_q;

  logic [DUTY_W-1:0] duty_step_d;
  logic [GAP_W-1:0]  gap;
  logic [GAP_W-1:0]  step_ext;
  logic              accept_start;
  logic [IVL_W-1:0]  start_ivlm1;
  logic              tick;
  logic              timer_load;
  logic [IVL_W-1:0]  timer_load_val;

  // A start only counts in IDLE when neither abort nor a direct write claims the cycle.
  assign accept_start = (state_q == IDLE) && bus.fade_start &&
                        !bus.fade_abort && !bus.cfg_duty_wr;
  assign start_ivlm1  = IVL_W'(clampToOne(32'(bus.fade_interval)) - 1);

  // The timer is armed on start and re-armed after every step it triggers.
  assign timer_load     = accept_start || ((state_q == RAMP) && tick);
  assign timer_load_val = accept_start ? start_ivlm1 : ivlm1_q;

  fade_tick_timer #(.IVL_W(IVL_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (timer_load),
    .load_val_i (timer_load_val),
    .tick_o     (tick)
  );

  // Next duty after one step, computed one bit wider so it lands on the target instead of wrapping.
  always_comb begin
    step_ext    = GAP_W'(step_q);
    gap         = dir_up_q ? ({1'b0, target_q} - {1'b0, duty_q})
                           : ({1'b0, duty_q} - {1'b0, target_q});
    duty_step_d = duty_q;
    if (gap <= step_ext) begin
      duty_step_d = target_q;
    end else if (dir_up_q) begin
      duty_step_d = duty_q + DUTY_W'(step_q);
    end else begin
      duty_step_d = duty_q - DUTY_W'(step_q);
    end
  end

  // Fade FSM with registered duty/busy/done; abort beats a direct write, which beats a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      duty_q   <= '0;
      target_q <= '0;
      step_q   <= '0;
      ivlm1_q  <= '0;
      dir_up_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!bus.fade_abort) begin
            if (bus.cfg_duty_wr) begin
              duty_q <= bus.cfg_duty;
            end else if (bus.fade_start) begin
              target_q <= bus.fade_target;
              step_q   <= STEP_W'(clampToOne(32'(bus.fade_step)));
              ivlm1_q  <= start_ivlm1;
              dir_up_q <= (bus.fade_target > duty_q);
              if (bus.fade_target == duty_q) begin
                done_q <= 1'b1;
              end else begin
                state_q <= RAMP;
                busy_q  <= 1'b1;
              end
            end
          end
        end
        RAMP: begin
          if (bus.fade_abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (bus.cfg_duty_wr) begin
            duty_q  <= bus.cfg_duty;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (tick) begin
            duty_q <= duty_step_d;
            if (duty_step_d == target_q) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pwm_duty_cycle = duty_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Bench for pwm_fade_sequencer: directed scenarios followed by random
// traffic, all checked against a plan-based model of the fade behaviour.
module tb_pwm_fade_sequencer;

   logic clk;
   logic rst_n;

   pwm_fade_sequencer_if ifc ();

   pwm_fade_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int totalChecks = 0;
   int badChecks   = 0;

   int      mDuty;
   bit      mBusy;
   bit      mDone;
   int      mIvl;
   int      plan[$];
   longint  edgeCount = 0;
   longint  nextDue   = 0;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      totalChecks++;
      if (got !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model reset: duty zero, nothing scheduled.
   task automatic modelReset();
      mDuty = 0;
      mBusy = 0;
      mDone = 0;
      plan.delete();
   endtask

   // Model of one clock edge: a fade is a precomputed list of duty values,
   // one released every mIvl edges after the edge that accepted the start.
   task automatic modelEdge(input logic wr, input logic [7:0] cfg, input logic start,
                            input logic abort, input logic [7:0] tgt,
                            input logic [3:0] stp, input logic [15:0] ivl);
      int d;
      int t;
      int s;
      edgeCount++;
      mDone = 0;
      if (abort) begin
         mBusy = 0;
         plan.delete();
      end else if (wr) begin
         mDuty = int'(cfg);
         mBusy = 0;
         plan.delete();
      end else if (start && !mBusy) begin
         t = int'(tgt);
         if (t == mDuty) begin
            mDone = 1;
         end else begin
            s = (stp == 0) ? 1 : int'(stp);
            mIvl = (ivl == 0) ? 1 : int'(ivl);
            d = mDuty;
            plan.delete();
            while (d != t) begin
               if (((t > d) ? (t - d) : (d - t)) <= s) d = t;
               else if (t > d) d = d + s;
               else d = d - s;
               plan.push_back(d);
            end
            nextDue = edgeCount + longint'(mIvl);
            mBusy = 1;
         end
      end else if (mBusy && edgeCount == nextDue) begin
         mDuty = plan.pop_front();
         nextDue = nextDue + longint'(mIvl);
         if (plan.size() == 0) begin
            mBusy = 0;
            mDone = 1;
         end
      end
   endtask

   // Drive one cycle of inputs, let the edge happen, then compare DUT with model.
   task automatic applyStimulus(input logic wr, input logic [7:0] cfg, input logic start,
                                input logic abort, input logic [7:0] tgt,
                                input logic [3:0] stp, input logic [15:0] ivl);
      ifc.cfg_duty_wr   = wr;
      ifc.cfg_duty      = cfg;
      ifc.fade_start    = start;
      ifc.fade_abort    = abort;
      ifc.fade_target   = tgt;
      ifc.fade_step     = stp;
      ifc.fade_interval = ivl;
      @(posedge clk);
      #1;
      modelEdge(wr, cfg, start, abort, tgt, stp, ivl);
      checkOutput("duty", 32'(ifc.pwm_duty_cycle), 32'(mDuty));
      checkOutput("busy", 32'(ifc.busy), 32'(mBusy));
      checkOutput("done", 32'(ifc.done), 32'(mDone));
   endtask

   task automatic idleCycles(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'h0, 16'h0);
   endtask

   task automatic writeDuty(input logic [7:0] value);
      applyStimulus(1'b1, value, 1'b0, 1'b0, 8'h00, 4'h0, 16'h0);
   endtask

   task automatic startFade(input logic [7:0] tgt, input logic [3:0] stp, input logic [15:0] ivl);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, tgt, stp, ivl);
   endtask

   int downExp[4] = '{32'h18, 32'h10, 32'h08, 32'h05};
   int clampExp[3] = '{32'h01, 32'h02, 32'h03};

   // Main sequence: reset, directed scenarios, then randomized traffic.
   initial begin
      logic        wr;
      logic        start;
      logic        abort;
      logic [7:0]  cfg;
      logic [7:0]  tgt;
      logic [3:0]  stp;
      logic [15:0] ivl;
      int          r;

      rst_n = 1'b0;
      ifc.cfg_duty_wr   = 1'b0;
      ifc.cfg_duty      = '0;
      ifc.fade_start    = 1'b0;
      ifc.fade_abort    = 1'b0;
      ifc.fade_target   = '0;
      ifc.fade_step     = '0;
      ifc.fade_interval = '0;
      modelReset();

      @(posedge clk);
      #2;
      checkOutput("rst_duty", 32'(ifc.pwm_duty_cycle), 32'h0);
      checkOutput("rst_busy", 32'(ifc.busy), 32'h0);
      checkOutput("rst_done", 32'(ifc.done), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] up-ramp");
      writeDuty(8'h10);
      startFade(8'h40, 4'd8, 16'd4);
      for (int k = 1; k <= 24; k++) begin
         idleCycles(1);
         if (k == 4)  checkOutput("up_first",  32'(ifc.pwm_duty_cycle), 32'h18);
         if (k == 8)  checkOutput("up_second", 32'(ifc.pwm_duty_cycle), 32'h20);
         if (k == 23) checkOutput("up_busy",   32'(ifc.busy), 32'h1);
         if (k == 24) begin
            checkOutput("up_final",     32'(ifc.pwm_duty_cycle), 32'h40);
            checkOutput("up_done",      32'(ifc.done), 32'h1);
            checkOutput("up_busy_fell", 32'(ifc.busy), 32'h0);
         end
      end
      idleCycles(1);
      checkOutput("up_done_pulse", 32'(ifc.done), 32'h0);

      $display("[TB] down-ramp");
      writeDuty(8'h20);
      startFade(8'h05, 4'd8, 16'd1);
      for (int k = 0; k < 4; k++) begin
         idleCycles(1);
         checkOutput("down_step", 32'(ifc.pwm_duty_cycle), 32'(downExp[k]));
      end
      checkOutput("down_done", 32'(ifc.done), 32'h1);
      idleCycles(2);
      checkOutput("down_hold", 32'(ifc.pwm_duty_cycle), 32'h05);

      $display("[TB] override");
      writeDuty(8'h00);
      startFade(8'hF0, 4'd4, 16'd2);
      idleCycles(3);
      writeDuty(8'h80);
      checkOutput("ovr_duty", 32'(ifc.pwm_duty_cycle), 32'h80);
      checkOutput("ovr_busy", 32'(ifc.busy), 32'h0);
      checkOutput("ovr_done", 32'(ifc.done), 32'h0);
      idleCycles(3);

      $display("[TB] priority");
      writeDuty(8'h10);
      startFade(8'hC0, 4'd5, 16'd1);
      idleCycles(4);
      applyStimulus(1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 4'h0, 16'h0);
      checkOutput("prio_frozen", 32'(ifc.pwm_duty_cycle), 32'h24);
      checkOutput("prio_busy",   32'(ifc.busy), 32'h0);
      idleCycles(3);

      $display("[TB] clamps");
      writeDuty(8'h00);
      startFade(8'h03, 4'd0, 16'd0);
      for (int k = 0; k < 3; k++) begin
         idleCycles(1);
         checkOutput("clamp_step", 32'(ifc.pwm_duty_cycle), 32'(clampExp[k]));
      end
      idleCycles(1);
      startFade(8'h03, 4'd5, 16'd9);
      checkOutput("noop_done", 32'(ifc.done), 32'h1);
      checkOutput("noop_busy", 32'(ifc.busy), 32'h0);
      idleCycles(1);
      checkOutput("noop_busy_after", 32'(ifc.busy), 32'h0);

      $display("[TB] reset mid-fade");
      writeDuty(8'h30);
      startFade(8'h90, 4'd1, 16'd2);
      idleCycles(5);
      checkOutput("mid_busy", 32'(ifc.busy), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_duty", 32'(ifc.pwm_duty_cycle), 32'h0);
      checkOutput("mid_rst_busy", 32'(ifc.busy), 32'h0);
      checkOutput("mid_rst_done", 32'(ifc.done), 32'h0);
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] random traffic");
      for (int i = 0; i < 1500; i++) begin
         r     = int'($urandom_range(0, 99));
         wr    = (r < 3);
         start = (r >= 3 && r < 13);
         abort = (r >= 13 && r < 15);
         if ($urandom_range(0, 29) == 0) begin
            wr    = 1'b1;
            start = 1'b1;
         end
         cfg = 8'($urandom);
         tgt = ($urandom_range(0, 4) == 0) ? 8'(mDuty) : 8'($urandom);
         stp = 4'($urandom_range(0, 15));
         ivl = 16'($urandom_range(0, 4));
         applyStimulus(wr, cfg, start, abort, tgt, stp, ivl);
         checkOutput("busy_done_excl", 32'(ifc.busy & ifc.done), 32'h0);
      end

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
